lvds_deframer: RTL and testbench
================================

// Module: lvds_deframer
// PURPOSE
// - Stage directly after the LVDS data recovery unit. Accepts its recovered nibble stream
//   (valid strobe, last flag) and assembles bytes, high nibble first.
// - Delimits packets, checks length, and optionally checks a trailing CRC-8.
// - Emits a byte stream with sop/eop/err flags and keeps saturating packet/error counters.
// - The link cannot be stalled, so there is no backpressure; the output is valid-only.
// PARAMETERS
// - MAX_BYTES  default 64  max bytes per packet incl. CRC byte; bytes beyond this are dropped
// - CW         default 16  width of the status counters
// PORTS
// - c          in   1       clock, 400 MHz; the only clock
// - r          in   1       reset, synchronous, active-high
// - nd         in   4       nibble from recovery unit
// - nv         in   1       nd valid; at most one per 2 cycles, but any rate must be tolerated
// - nl         in   1       last nibble of packet; qualified by nv
// - od         out  8       output byte
// - ov         out  1       od valid (1-cycle pulse)
// - osop       out  1       first byte of packet; qualified by ov
// - oeop       out  1       last byte of packet; qualified by ov
// - oerr       out  1       packet bad; qualified by ov&oeop
// - pkt_cnt    out  CW      good packets, saturates at all-ones
// - err_cnt    out  CW      bad packets, saturates at all-ones
// BEHAVIOUR
// - Reset: od=0, ov=osop=oeop=oerr=0, pkt_cnt=err_cnt=0, FSM=HI, len=0, crc=0, ovf=0.
//   Reset mid-packet discards the partial packet; no eop is emitted for it.
// - FSM states: HI (wait high nibble), LO (have high nibble), DROP (overlength, wait last).
//   - HI, nv&~nl: latch hi=nd -> LO.
//   - HI, nv&nl: odd-nibble packet. Emit od={nd,4'h0} with eop=1, err=1 -> HI.
//   - LO, nv: byte b={hi,nd}.
//     - len<MAX_BYTES: emit b, len++.
//     - len==MAX_BYTES: set ovf, emit nothing.
//     - Next state: nl -> HI, eop path. ~nl&~ovf -> HI. ~nl&ovf -> DROP.
//   - DROP, nv&nl: emit eop -> HI. Other nibbles ignored.
//   - Every nv with nl ends a packet regardless of state.
// - Latency: ov asserts exactly 1 cycle after the nv that completes the byte. od/flags are
//   registered.
// - osop=1 on the first byte emitted after reset or after an eop (len==0).
// - Overlength eop: eop has no byte to attach to. Emit a pulse ov=1, od=8'h00, oeop=1, oerr=1.
// - Empty (zero-byte) packets cannot occur: the minimum packet is one nibble.
// - At eop, len, crc and ovf clear on the same cycle. A packet starting on the very next nv
//   has a clean state.
// - oerr = odd | ovf | crc_bad (crc_bad only with the macro below).
// - Counters: pkt_cnt++ on a good eop; err_cnt++ on a bad eop; each holds at 2^CW-1.
// - len counter is $clog2(MAX_BYTES+1) bits and never wraps.
// CONFIGURATION
// - LVDS_DEFRAMER_CRC_EN defined:
//   - CRC-8, poly x^8+x^2+x+1 (0x07), init 0x00, MSB first, over all bytes including the
//     final CRC byte.
//   - Residue !=0 at eop -> crc_bad.
//   - CRC byte is still emitted on od (with eop); the consumer strips it.
//   - A one-byte packet is checked normally.
// - Undefined: no CRC logic and crc_bad=0. The last byte is ordinary data; oerr is
//   odd|ovf only.
// TESTING
// - Reset, nibbles 0,1,0,2 (nl on the 4th), nv every 2nd cycle.
//   -> bytes 01(sop), 02(eop), err=0, pkt_cnt=1.
// - CRC_EN: nibbles 0,1,0,2,1,B (nl on B) -> 01,02,1B, eop err=0.
//   Same with last nibble C -> eop err=1, err_cnt=1.
// - Three nibbles A,5,3 with nl on 3 -> A5(sop), then 30 with eop, err=1.
// - MAX_BYTES=4, 12 nibbles -> 4 bytes out, then od=00 eop err=1.
//   The next 2-byte packet is clean with sop.
// - nv on consecutive cycles (back-to-back packets, eop then next nv).
//   -> no byte loss; sop on the new packet's first byte.
// - Assert r after 3 bytes of a packet, release, send 2-byte packet.
//   -> only the new packet appears, with sop; counters were zeroed by reset.
// - Force pkt_cnt to 2^CW-1 and send a good packet -> pkt_cnt stays 2^CW-1.

Source files
------------

// File: rtl/lvds_deframer.sv
// lvds_deframer: assembles recovered LVDS nibbles into bytes (high nibble first), delimits packets,
// enforces MAX_BYTES and keeps saturating counters; define LVDS_DEFRAMER_CRC_EN for the CRC-8 check.
module lvds_deframer #(
    parameter int MAX_BYTES = 64,
    parameter int CW        = 16
) (
    input  logic          c,
    input  logic          r,
    input  logic [3:0]    nd,
    input  logic          nv,
    input  logic          nl,
    output logic [7:0]    od,
    output logic          ov,
    output logic          osop,
    output logic          oeop,
    output logic          oerr,
    output logic [CW-1:0] pkt_cnt,
    output logic [CW-1:0] err_cnt
);
    localparam int LW = $clog2(MAX_BYTES + 1);
    typedef enum logic [1:0] {HI, LO, DROP} state_t;
    state_t        r_state;
    logic [3:0]    r_hi;
    logic [LW-1:0] r_len;
    logic          r_ovf;
    logic [7:0]    w_byte;
    logic          w_full, w_eop, w_take, w_odd, w_bad, w_crc_bad;
    assign w_byte = {r_hi, nd};
    assign w_full = r_len == LW'(MAX_BYTES);
    assign w_eop  = nv & nl;
    assign w_take = nv & (r_state == LO) & ~w_full;
    assign w_odd  = w_eop & (r_state == HI);
    // A byte arriving with the packet already full is the overflow that ends or drops the packet.
    assign w_bad  = w_odd | r_ovf | ((r_state == LO) & w_full) | w_crc_bad;
`ifdef LVDS_DEFRAMER_CRC_EN
    logic [7:0] r_crc, w_crc_nx;
    function automatic logic [7:0] crc_next(input logic [7:0] crc, input logic [7:0] b);
        logic [7:0] x;
        x = crc ^ b;
        for (int i = 0; i < 8; i++) x = x[7] ? ((x << 1) ^ 8'h07) : (x << 1);
        return x;
    endfunction
    assign w_crc_nx  = crc_next(r_crc, w_byte);
    assign w_crc_bad = w_crc_nx != 8'h00;
    always_ff @(posedge c) begin
        if (r || w_eop) r_crc <= 8'h00;
        else if (w_take) r_crc <= w_crc_nx;
    end
`else
    assign w_crc_bad = 1'b0;
`endif
    always_ff @(posedge c) begin
        if (r) begin
            r_state <= HI;
            r_hi    <= 4'h0;
            r_len   <= '0;
            r_ovf   <= 1'b0;
            od      <= 8'h00;
            ov      <= 1'b0;
            osop    <= 1'b0;
            oeop    <= 1'b0;
            oerr    <= 1'b0;
            pkt_cnt <= '0;
            err_cnt <= '0;
        end else begin
            ov   <= w_take | w_eop;
            od   <= w_take ? w_byte : (w_odd && !w_full) ? {nd, 4'h0} : 8'h00;
            osop <= (w_take | w_eop) && r_len == '0;
            oeop <= w_eop;
            oerr <= w_eop & w_bad;
            if (w_eop) begin
                r_state <= HI;
                r_len   <= '0;
                r_ovf   <= 1'b0;
                if (w_bad) err_cnt <= err_cnt + CW'(~&err_cnt);
                else pkt_cnt <= pkt_cnt + CW'(~&pkt_cnt);
            end else if (nv) begin
                case (r_state)
                    HI: begin
                        r_hi    <= nd;
                        r_state <= LO;
                    end
                    LO: begin
                        r_state <= w_full ? DROP : HI;
                        r_ovf   <= w_full;
                        if (!w_full) r_len <= r_len + 1'b1;
                    end
                    default: r_state <= DROP;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_lvds_deframer.sv
// tb_lvds_deframer: directed table, hand corner sequences and random packets checked against a
// packet-level reference model of lvds_deframer (CRC checks follow LVDS_DEFRAMER_CRC_EN).
module tb_lvds_deframer;
    localparam int MAXB = 4;
    localparam int CW   = 4;
`ifdef LVDS_DEFRAMER_CRC_EN
    localparam bit CRC = 1'b1;
`else
    localparam bit CRC = 1'b0;
`endif
    logic clk = 1'b0, rst = 1'b1, nv = 1'b0, nl = 1'b0;
    logic [3:0] nd = 4'h0;
    logic [7:0] od;
    logic ov, osop, oeop, oerr;
    logic [CW-1:0] pkt_cnt, err_cnt;
    typedef struct { logic [7:0] d; logic s; logic e; logic x; } ev_t;
    typedef struct { int n; logic [47:0] nib; int gap; logic [7:0] last; logic err; int cnt; } vec_t;
    ev_t got[$], exp_q[$];
    logic [3:0] pkt[$];
    vec_t tbl[7];
    int n_chk = 0, n_fail = 0, m_pkt = 0, m_err = 0;

    always #5 clk = ~clk;

    lvds_deframer #(.MAX_BYTES(MAXB), .CW(CW)) u_dut (
        .c(clk), .r(rst), .nd(nd), .nv(nv), .nl(nl), .od(od), .ov(ov), .osop(osop),
        .oeop(oeop), .oerr(oerr), .pkt_cnt(pkt_cnt), .err_cnt(err_cnt)
    );

    always @(negedge clk) if (ov === 1'b1) got.push_back('{od, osop, oeop, oerr});

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    // Remainder of M(x)*x^8 mod (x^8+x^2+x+1) by long division; zero means the CRC byte matches.
    function automatic logic [7:0] residue(input logic [7:0] b[$]);
        logic [8:0] rem = 9'h000;
        for (int i = 0; i < b.size() + 1; i++)
            for (int k = 7; k >= 0; k--) begin
                rem = {rem[7:0], (i < b.size()) ? b[i][k] : 1'b0};
                if (rem[8]) rem = rem ^ 9'h107;
            end
        return rem[7:0];
    endfunction

    task automatic model();
        logic [7:0] b[$];
        int nb;
        logic bad;
        for (int i = 0; i < pkt.size(); i += 2)
            b.push_back({pkt[i], (i + 1 < pkt.size()) ? pkt[i + 1] : 4'h0});
        nb = b.size();
        if (nb > MAXB) begin
            for (int i = 0; i < MAXB; i++) exp_q.push_back('{b[i], i == 0, 1'b0, 1'b0});
            exp_q.push_back('{8'h00, 1'b0, 1'b1, 1'b1});
            bad = 1'b1;
        end else begin
            bad = (pkt.size() % 2 == 1) || (CRC && residue(b) != 8'h00);
            for (int i = 0; i < nb; i++) exp_q.push_back('{b[i], i == 0, i == nb - 1, (i == nb - 1) && bad});
        end
        if (bad) m_err = (m_err < 2**CW - 1) ? m_err + 1 : m_err;
        else m_pkt = (m_pkt < 2**CW - 1) ? m_pkt + 1 : m_pkt;
    endtask

    task automatic send(input int gap);
        model();
        foreach (pkt[i]) begin
            nd = pkt[i];
            nv = 1'b1;
            nl = (i == pkt.size() - 1);
            @(posedge clk); #1;
            nv = 1'b0;
            nl = 1'b0;
            repeat (gap - 1) begin @(posedge clk); #1; end
        end
        pkt.delete();
    endtask

    task automatic load(input logic [47:0] nib, input int n);
        for (int i = 0; i < n; i++) pkt.push_back(nib[47 - 4*i -: 4]);
    endtask

    task automatic settle();
        repeat (3) begin @(posedge clk); #1; end
    endtask

    task automatic compare(input string name);
        chk({name, " count"}, got.size(), exp_q.size());
        while (got.size() > 0 && exp_q.size() > 0) begin
            ev_t g, e;
            g = got.pop_front();
            e = exp_q.pop_front();
            chk({name, " byte/sop/eop/err"}, {g.d, g.s, g.e, g.x}, {e.d, e.s, e.e, e.x});
        end
        got.delete();
        exp_q.delete();
        chk({name, " pkt_cnt"}, pkt_cnt, m_pkt);
        chk({name, " err_cnt"}, err_cnt, m_err);
    endtask

    initial begin
        tbl[0] = '{4,  48'h0102_0000_0000, 2, 8'h02, CRC,  2};
        tbl[1] = '{3,  48'hA530_0000_0000, 2, 8'h30, 1'b1, 2};
        tbl[2] = '{12, 48'h1234_5678_9ABC, 2, 8'h00, 1'b1, 5};
        tbl[3] = '{1,  48'h7000_0000_0000, 2, 8'h70, 1'b1, 1};
        tbl[4] = '{6,  48'h0102_1B00_0000, 1, 8'h1B, 1'b0, 3};
        tbl[5] = '{6,  48'h0102_1C00_0000, 2, 8'h1C, CRC,  3};
        tbl[6] = '{9,  48'h1234_5678_9000, 1, 8'h00, 1'b1, 5};
        repeat (3) @(posedge clk);
        #1;
        chk("reset outputs", {od, ov, osop, oeop, oerr}, 12'h000);
        chk("reset pkt_cnt", pkt_cnt, 0);
        chk("reset err_cnt", err_cnt, 0);
        rst = 1'b0;
        @(posedge clk); #1;
        for (int k = 0; k < 7; k++) begin
            load(tbl[k].nib, tbl[k].n);
            send(tbl[k].gap);
            settle();
            chk($sformatf("tbl%0d count", k), got.size(), tbl[k].cnt);
            if (got.size() > 0) begin
                chk($sformatf("tbl%0d first sop", k), got[0].s, 1'b1);
                chk($sformatf("tbl%0d last byte", k), got[got.size() - 1].d, tbl[k].last);
                chk($sformatf("tbl%0d last eop/err", k), {got[got.size() - 1].e, got[got.size() - 1].x}, {1'b1, tbl[k].err});
            end
            compare($sformatf("tbl%0d model", k));
        end
        // Back-to-back packets: the second packet's first nv follows the eop nv directly.
        load(48'h0102_0000_0000, 4);
        send(1);
        load(48'hA5C3_0000_0000, 4);
        send(1);
        settle();
        chk("b2b count", got.size(), 4);
        if (got.size() == 4) chk("b2b second sop", {got[2].d, got[2].s}, {8'hA5, 1'b1});
        compare("b2b model");
        // Reset three bytes into a packet: the partial packet must vanish.
        for (int i = 0; i < 6; i++) begin
            nd = 4'(i + 1);
            nv = 1'b1;
            @(posedge clk); #1;
            nv = 1'b0;
            @(posedge clk); #1;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        got.delete();
        chk("midrst ov", ov, 1'b0);
        chk("midrst counters", {pkt_cnt, err_cnt}, 0);
        rst = 1'b0;
        m_pkt = 0;
        m_err = 0;
        load(48'h4D2E_0000_0000, 4);
        send(2);
        settle();
        chk("midrst count", got.size(), 2);
        if (got.size() > 0) chk("midrst sop byte", {got[0].d, got[0].s}, {8'h4D, 1'b1});
        compare("midrst model");
        // Good packets past the counter ceiling.
        for (int k = 0; k < 2**CW + 1; k++) begin
            load(48'h0102_1B00_0000, 6);
            send(2);
            settle();
            compare("sat model");
        end
        chk("sat pkt_cnt hold", pkt_cnt, 2**CW - 1);
        for (int k = 0; k < 30; k++) begin
            for (int p = 0; p < 3; p++) begin
                int n;
                n = $urandom_range(1, 12);
                for (int i = 0; i < n; i++) pkt.push_back(4'($urandom));
                send($urandom_range(1, 3));
            end
            settle();
            compare($sformatf("rand%0d", k));
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
